regfile_readback: RTL and testbench
===================================

REGFILE_READBACK -- requirements
Module: regfile_readback

Interface
- REQ-001 SHALL have parameter ADDR_W, default 12, regfile address width.
- REQ-002 SHALL have parameter DATA_W, default 32, InexRecur word width; the state word width is fixed at 18.
- REQ-003 SHALL have these ports:
  - clk, input, 1: the single clock; all logic on its rising edge.
  - rst_n, input, 1: synchronous, active-low reset.
- REQ-004 SHALL have these control ports:
  - start, input, 1: one-cycle request to begin a dump.
  - src_sel, input, 1: source select; 0 = InexRecur, 1 = state. Sampled on start.
  - base_addr, input, ADDR_W: first address. Sampled on start.
  - count, input, ADDR_W+1: number of words, range 0..4096. Sampled on start.
  - busy, output, 1: a dump is in progress.
  - done, output, 1: one-cycle pulse at the end of a dump.
- REQ-005 SHALL have these regfile read ports:
  - rd_en_InexRecur, output, 1: read strobe.
  - rd_addr_InexRecur, output, ADDR_W: read address.
  - rd_data_InexRecur, input, DATA_W: read data, valid 1 cycle after the strobe.
  - rd_en_state, output, 1: read strobe.
  - rd_addr_state, output, ADDR_W: read address.
  - rd_data_state, input, 18: read data, valid 1 cycle after the strobe.
- REQ-006 SHALL have these output stream ports:
  - out_valid, output, 1: a beat is presented.
  - out_ready, input, 1: the sink accepts.
  - out_data, output, DATA_W: the word.
  - out_addr, output, ADDR_W: the source address of the word.
  - out_last, output, 1: marks the final beat.

Function
- REQ-007 SHALL implement an FSM with states IDLE, READ, DRAIN and DONE.
- REQ-008 In IDLE with start=1 and count>0, SHALL latch src_sel, base_addr and count, and enter READ.
- REQ-009 In IDLE with start=1 and count=0, SHALL enter DONE with no reads issued.
- REQ-010 In READ, SHALL assert the selected rd_en only when (FIFO occupancy + reads in flight) < 2; the non-selected rd_en SHALL stay 0.
- REQ-011 SHALL place rd_data into the FIFO exactly 1 cycle after the strobe, tagged with its address. State data SHALL be zero-extended to DATA_W.
- REQ-012 The read address SHALL start at base_addr and increment by 1 per issued read, wrapping from 2^ADDR_W-1 to 0.
- REQ-013 SHALL leave READ for DRAIN in the cycle after the count-th read is issued.
- REQ-014 SHALL leave DRAIN for DONE once the last beat has been accepted (out_valid & out_ready).
- REQ-015 DONE SHALL last exactly 1 cycle with done=1, then return to IDLE.
- REQ-016 busy SHALL be 1 in READ, DRAIN and DONE, and 0 in IDLE.
- REQ-017 start while busy=1 SHALL be ignored, with no change to latched parameters.
- REQ-018 out_valid SHALL stay asserted, with out_data, out_addr and out_last held stable, until accepted; no beat SHALL be dropped or duplicated under any out_ready pattern.
- REQ-019 out_last SHALL be 1 only on the count-th beat.
- REQ-020 With out_ready held at 1, SHALL sustain 1 beat per cycle. First-beat latency SHALL be 2 cycles after start (start at cycle N, rd_en at N+1, out_valid at N+2).

Reset
- REQ-021 When rst_n=0 at a clk edge, SHALL enter IDLE and drive the following 0: busy, done, both rd_en, both rd_addr, out_valid, out_data, out_addr and out_last. The FIFO SHALL be empty and the in-flight count 0.
- REQ-022 Reset mid-dump SHALL abandon the dump; no done pulse SHALL follow, and the first post-reset start SHALL behave as from power-up.

Configuration
- REQ-023 With READBACK_CHECKSUM_EN defined, SHALL add output checksum [DATA_W-1:0]:
  - cleared on an accepted start;
  - XOR-accumulates every accepted out_data;
  - stable from the DONE cycle until the next accepted start;
  - 0 after reset.
- REQ-024 Without READBACK_CHECKSUM_EN, the checksum port and its logic SHALL be absent; all other behaviour is identical.

Structure
- REQ-025 Package accel_readback_pkg SHALL hold:
  - the ADDR_W/DATA_W defaults;
  - the STATE_W=18 constant;
  - the FSM state typedef (IDLE, READ, DRAIN, DONE);
  - the FIFO depth constant (2).
- REQ-026 The 2-entry {addr, data, last} FIFO SHALL be sub-module rb_skid_fifo, with ports: push, push data, pop and occupancy.

Verification
- REQ-027 InexRecur[0]=32'h02010006; start with src_sel=0, base_addr=0, count=1 and out_ready=1 -> rd_en_InexRecur at N+1, and at N+2 a single beat with out_data=32'h02010006, out_addr=0, out_last=1; done=1 at N+3.
- REQ-028 state[5..8]=18'h3FFFF,0,1,2; start with src_sel=1, base_addr=5, count=4 -> beats 32'h0003FFFF, 0, 1, 2 at addresses 5..8, out_last only on the 4th, rd_en_InexRecur never asserted.
- REQ-029 base_addr=12'hFFE, count=4 -> out_addr sequence FFE, FFF, 000, 001.
- REQ-030 count=8 with out_ready toggling 1,0,0,1 repeating -> exactly 8 beats in order with no duplicates, and rd_en never issued while occupancy + in-flight = 2.
- REQ-031 Corner cases:
  - count=0 -> done pulse at N+1 with no rd_en and no out_valid;
  - start during busy -> ignored;
  - rst_n=0 mid-dump -> all outputs 0 next cycle and no done pulse.
- REQ-032 With READBACK_CHECKSUM_EN and words 32'h1, 32'h2, 32'h4 -> checksum=32'h7 at the DONE cycle.

Source files
------------

// File: rtl/accel_readback_pkg.sv
// Shared constants and FSM state type for the regfile readback engine.
package accel_readback_pkg;

    localparam int DEF_ADDR_W = 12;
    localparam int DEF_DATA_W = 32;
    localparam int STATE_W    = 18;
    localparam int FIFO_DEPTH = 2;
    localparam int OCC_W      = $clog2(FIFO_DEPTH + 1);

    typedef enum logic [1:0] {
        IDLE,
        READ,
        DRAIN,
        DONE
    } rb_state_t;

endpackage

// File: rtl/rb_skid_fifo.sv
// Two-entry FIFO holding {addr, data, last} beats between the regfile read and the output stream.
module rb_skid_fifo
    import accel_readback_pkg::*;
#(
    parameter int WIDTH = DEF_ADDR_W + DEF_DATA_W + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic [OCC_W-1:0] occupancy
);

    logic [WIDTH-1:0] head;
    logic [WIDTH-1:0] tail;
    logic             pop_ok;
    logic             push_ok;

    assign pop_ok    = pop && (occupancy != '0);
    assign push_ok   = push && ((occupancy < OCC_W'(FIFO_DEPTH)) || pop_ok);
    assign head_data = head;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            occupancy <= '0;
            head      <= '0;
            tail      <= '0;
        end else begin
            case ({push_ok, pop_ok})
                2'b10: begin
                    if (occupancy == '0) begin
                        head <= push_data;
                    end else begin
                        tail <= push_data;
                    end
                    occupancy <= occupancy + OCC_W'(1);
                end
                2'b01: begin
                    head      <= tail;
                    occupancy <= occupancy - OCC_W'(1);
                end
                2'b11: begin
                    // Simultaneous push/pop: the new beat lands behind whatever remains.
                    if (occupancy == OCC_W'(1)) begin
                        head <= push_data;
                    end else begin
                        head <= tail;
                        tail <= push_data;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/regfile_readback.sv
// Streams a block of regfile words (InexRecur or state) out with address tags and a last marker.
// Optional running XOR of accepted words enabled by READBACK_CHECKSUM_EN.
module regfile_readback
    import accel_readback_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              src_sel,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   count,
    output logic              busy,
    output logic              done,
    output logic              rd_en_InexRecur,
    output logic [ADDR_W-1:0] rd_addr_InexRecur,
    input  logic [DATA_W-1:0] rd_data_InexRecur,
    output logic              rd_en_state,
    output logic [ADDR_W-1:0] rd_addr_state,
    input  logic [STATE_W-1:0] rd_data_state,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [ADDR_W-1:0] out_addr,
    output logic              out_last
`ifdef READBACK_CHECKSUM_EN
    ,
    output logic [DATA_W-1:0] checksum
`endif
);

    localparam int BEAT_W = ADDR_W + DATA_W + 1;
    localparam int CNT_W  = ADDR_W + 1;

    rb_state_t         state;
    logic              sel;
    logic [ADDR_W-1:0] next_addr;
    logic [ADDR_W-1:0] rd_addr_q;
    logic [CNT_W-1:0]  remaining;
    logic              rd_en_q;
    logic              rd_last_q;

    logic [DATA_W-1:0] rd_word;
    logic [BEAT_W-1:0] push_beat;
    logic [BEAT_W-1:0] head_beat;
    logic [BEAT_W-1:0] shown_beat;
    logic [OCC_W-1:0]  occupancy;
    logic [OCC_W:0]    fill;
    logic              accept;
    logic              issue;

    assign rd_word   = sel ? DATA_W'(rd_data_state) : rd_data_InexRecur;
    assign push_beat = {rd_addr_q, rd_word, rd_last_q};

    rb_skid_fifo #(
        .WIDTH(BEAT_W)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (rd_en_q),
        .push_data(push_beat),
        .pop      (accept),
        .head_data(head_beat),
        .occupancy(occupancy)
    );

    assign out_valid  = (occupancy != '0);
    assign accept     = out_valid && out_ready;
    assign shown_beat = out_valid ? head_beat : '0;
    assign out_addr   = shown_beat[BEAT_W-1 -: ADDR_W];
    assign out_data   = shown_beat[DATA_W:1];
    assign out_last   = shown_beat[0];

    assign rd_en_InexRecur   = rd_en_q && !sel;
    assign rd_en_state       = rd_en_q && sel;
    assign rd_addr_InexRecur = sel ? '0 : rd_addr_q;
    assign rd_addr_state     = sel ? rd_addr_q : '0;

    // Occupancy after this edge counts the strobe now up; a new read is allowed only if that leaves room.
    always_comb begin
        fill  = {1'b0, occupancy} + (OCC_W+1)'(rd_en_q) - (OCC_W+1)'(accept);
        issue = (state == READ) && (remaining != '0) && (fill < (OCC_W+1)'(FIFO_DEPTH));
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            sel       <= 1'b0;
            next_addr <= '0;
            rd_addr_q <= '0;
            remaining <= '0;
            rd_en_q   <= 1'b0;
            rd_last_q <= 1'b0;
        end else begin
            done    <= 1'b0;
            rd_en_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        sel  <= src_sel;
                        busy <= 1'b1;
                        if (count == '0) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            // First read goes out on the start edge itself to meet the 2-cycle latency.
                            state     <= READ;
                            rd_en_q   <= 1'b1;
                            rd_addr_q <= base_addr;
                            next_addr <= base_addr + ADDR_W'(1);
                            remaining <= count - CNT_W'(1);
                            rd_last_q <= (count == CNT_W'(1));
                        end
                    end
                end
                READ: begin
                    if (remaining == '0) begin
                        state <= DRAIN;
                    end else if (issue) begin
                        rd_en_q   <= 1'b1;
                        rd_addr_q <= next_addr;
                        next_addr <= next_addr + ADDR_W'(1);
                        remaining <= remaining - CNT_W'(1);
                        rd_last_q <= (remaining == CNT_W'(1));
                    end
                end
                DRAIN: begin
                    if (accept && out_last) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef READBACK_CHECKSUM_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            checksum <= '0;
        end else if (state == IDLE && start) begin
            checksum <= '0;
        end else if (accept) begin
            checksum <= checksum ^ out_data;
        end
    end
`endif

endmodule

// File: tb/tb_regfile_readback.sv
// Directed self-checking bench for regfile_readback; checksum case built only with READBACK_CHECKSUM_EN.
`timescale 1ns/1ps
module tb_regfile_readback;
    import accel_readback_pkg::*;

    localparam int ADDR_W = 12;
    localparam int DATA_W = 32;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              start;
    logic              src_sel;
    logic [ADDR_W-1:0] base_addr;
    logic [ADDR_W:0]   count;
    logic              busy;
    logic              done;
    logic              rd_en_InexRecur;
    logic [ADDR_W-1:0] rd_addr_InexRecur;
    logic [DATA_W-1:0] rd_data_InexRecur;
    logic              rd_en_state;
    logic [ADDR_W-1:0] rd_addr_state;
    logic [17:0]       rd_data_state;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [ADDR_W-1:0] out_addr;
    logic              out_last;
`ifdef READBACK_CHECKSUM_EN
    logic [DATA_W-1:0] checksum;
`endif

    regfile_readback #(
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .start            (start),
        .src_sel          (src_sel),
        .base_addr        (base_addr),
        .count            (count),
        .busy             (busy),
        .done             (done),
        .rd_en_InexRecur  (rd_en_InexRecur),
        .rd_addr_InexRecur(rd_addr_InexRecur),
        .rd_data_InexRecur(rd_data_InexRecur),
        .rd_en_state      (rd_en_state),
        .rd_addr_state    (rd_addr_state),
        .rd_data_state    (rd_data_state),
        .out_valid        (out_valid),
        .out_ready        (out_ready),
        .out_data         (out_data),
        .out_addr         (out_addr),
        .out_last         (out_last)
`ifdef READBACK_CHECKSUM_EN
        ,
        .checksum         (checksum)
`endif
    );

    always #5 clk = ~clk;

    // Regfile models: data presented while the strobe is up, captured by the DUT on the next edge.
    logic [DATA_W-1:0] inex_mem  [0:4095];
    logic [17:0]       state_mem [0:4095];
    assign rd_data_InexRecur = rd_en_InexRecur ? inex_mem[rd_addr_InexRecur] : '0;
    assign rd_data_state     = rd_en_state ? state_mem[rd_addr_state] : '0;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Stream monitor: records accepted beats and checks flow-control rules every cycle.
    int                occ_m = 0;
    int                done_pulses = 0;
    int                inex_strobes = 0;
    int                state_strobes = 0;
    logic              prev_stall = 1'b0;
    logic              prev_done = 1'b0;
    logic [DATA_W-1:0] prev_data;
    logic [ADDR_W-1:0] prev_addr;
    logic              prev_last;
    logic [DATA_W-1:0] got_data [$];
    logic [ADDR_W-1:0] got_addr [$];
    logic              got_last [$];

    always @(negedge clk) begin
        if (rst_n) begin
            if (rd_en_InexRecur || rd_en_state) begin
                check("rd_en_room", 64'(occ_m < 2), 64'(1));
                check("rd_en_exclusive", 64'(rd_en_InexRecur && rd_en_state), 64'(0));
            end
            check("valid_vs_model", 64'(out_valid), 64'(occ_m > 0));
            if (prev_stall) begin
                check("stall_hold", 64'({out_valid, out_last, out_addr, out_data}),
                      64'({1'b1, prev_last, prev_addr, prev_data}));
            end
            if (done) begin
                done_pulses++;
                check("done_single", 64'(prev_done), 64'(0));
            end
            if (rd_en_InexRecur) inex_strobes++;
            if (rd_en_state) state_strobes++;
            if (out_valid && out_ready) begin
                got_data.push_back(out_data);
                got_addr.push_back(out_addr);
                got_last.push_back(out_last);
            end
            occ_m = occ_m + int'(rd_en_InexRecur || rd_en_state) - int'(out_valid && out_ready);
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
            prev_addr  = out_addr;
            prev_last  = out_last;
            prev_done  = done;
        end else begin
            occ_m      = 0;
            prev_stall = 1'b0;
            prev_done  = 1'b0;
        end
    end

    logic       toggle_ready = 1'b0;
    logic [3:0] ready_pat = 4'b1001;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_log();
        got_data.delete();
        got_addr.delete();
        got_last.delete();
        done_pulses   = 0;
        inex_strobes  = 0;
        state_strobes = 0;
    endtask

    task automatic issue_start(input logic s, input logic [ADDR_W-1:0] b, input logic [ADDR_W:0] c);
        start     = 1'b1;
        src_sel   = s;
        base_addr = b;
        count     = c;
        tick();
        start = 1'b0;
    endtask

    // Called in cycle first_cycle after the start edge; returns the cycle index in which done is seen.
    task automatic wait_done(input string tag, input int first_cycle, output int cycles);
        cycles = first_cycle;
        while (!done && cycles < 300) begin
            if (toggle_ready) out_ready = ready_pat[(cycles - 1) % 4];
            tick();
            cycles++;
        end
        check({tag, "_done_seen"}, 64'(done), 64'(1));
    endtask

    task automatic check_beats(input string tag, input int n, input logic s, input logic [ADDR_W-1:0] b);
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] d;
        check({tag, "_nbeats"}, 64'(got_data.size()), 64'(n));
        for (int i = 0; i < n && i < got_data.size(); i++) begin
            a = b + ADDR_W'(i);
            d = s ? DATA_W'(state_mem[a]) : inex_mem[a];
            check({tag, "_addr"}, 64'(got_addr[i]), 64'(a));
            check({tag, "_data"}, 64'(got_data[i]), 64'(d));
            check({tag, "_last"}, 64'(got_last[i]), 64'(i == n - 1));
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_busy"}, 64'(busy), 64'(0));
        check({tag, "_done"}, 64'(done), 64'(0));
        check({tag, "_rd_en_inex"}, 64'(rd_en_InexRecur), 64'(0));
        check({tag, "_rd_en_state"}, 64'(rd_en_state), 64'(0));
        check({tag, "_rd_addr_inex"}, 64'(rd_addr_InexRecur), 64'(0));
        check({tag, "_rd_addr_state"}, 64'(rd_addr_state), 64'(0));
        check({tag, "_out_valid"}, 64'(out_valid), 64'(0));
        check({tag, "_out_data"}, 64'(out_data), 64'(0));
        check({tag, "_out_addr"}, 64'(out_addr), 64'(0));
        check({tag, "_out_last"}, 64'(out_last), 64'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int cyc;
        for (int i = 0; i < 4096; i++) begin
            inex_mem[i]  = 32'hC000_0000 | 32'(i);
            state_mem[i] = 18'(i * 7 + 3);
        end
        rst_n     = 1'b0;
        start     = 1'b0;
        src_sel   = 1'b0;
        base_addr = '0;
        count     = '0;
        out_ready = 1'b1;
        tick();
        tick();
        check_idle_outputs("reset");
        rst_n = 1'b1;
        tick();

        // Single InexRecur word: strobe at N+1, beat at N+2, done at N+3.
        inex_mem[0] = 32'h0201_0006;
        clear_log();
        issue_start(1'b0, 12'h000, 13'd1);
        check("t1_rd_en_inex", 64'(rd_en_InexRecur), 64'(1));
        check("t1_rd_en_state", 64'(rd_en_state), 64'(0));
        check("t1_rd_addr", 64'(rd_addr_InexRecur), 64'(0));
        check("t1_busy", 64'(busy), 64'(1));
        check("t1_valid_early", 64'(out_valid), 64'(0));
        tick();
        check("t1_valid", 64'(out_valid), 64'(1));
        check("t1_data", 64'(out_data), 64'(32'h0201_0006));
        check("t1_addr", 64'(out_addr), 64'(0));
        check("t1_last", 64'(out_last), 64'(1));
        check("t1_rd_en_off", 64'(rd_en_InexRecur), 64'(0));
        tick();
        check("t1_done", 64'(done), 64'(1));
        check("t1_valid_after", 64'(out_valid), 64'(0));
        tick();
        check("t1_done_clear", 64'(done), 64'(0));
        check("t1_idle", 64'(busy), 64'(0));
        check("t1_nbeats", 64'(got_data.size()), 64'(1));

        // State source, zero-extended, back-to-back at full throughput.
        state_mem[5] = 18'h3FFFF;
        state_mem[6] = 18'h00000;
        state_mem[7] = 18'h00001;
        state_mem[8] = 18'h00002;
        clear_log();
        issue_start(1'b1, 12'd5, 13'd4);
        wait_done("t2", 1, cyc);
        check("t2_done_cycle", 64'(cyc), 64'(6));
        check_beats("t2", 4, 1'b1, 12'd5);
        if (got_data.size() == 4) begin
            check("t2_word0", 64'(got_data[0]), 64'(32'h0003_FFFF));
            check("t2_word3", 64'(got_data[3]), 64'(32'h0000_0002));
        end
        check("t2_no_inex", 64'(inex_strobes), 64'(0));
        check("t2_state_reads", 64'(state_strobes), 64'(4));
        tick();

        // Address wrap at the top of the regfile.
        inex_mem[12'hFFE] = 32'hAAAA_0FFE;
        inex_mem[12'hFFF] = 32'hAAAA_0FFF;
        inex_mem[12'h001] = 32'hAAAA_0001;
        clear_log();
        issue_start(1'b0, 12'hFFE, 13'd4);
        wait_done("t3", 1, cyc);
        check_beats("t3", 4, 1'b0, 12'hFFE);
        if (got_addr.size() == 4) begin
            check("t3_wrap_a2", 64'(got_addr[2]), 64'(12'h000));
            check("t3_wrap_a3", 64'(got_addr[3]), 64'(12'h001));
            check("t3_word2", 64'(got_data[2]), 64'(32'h0201_0006));
        end
        tick();

        // Backpressure: out_ready cycles 1,0,0,1.
        toggle_ready = 1'b1;
        clear_log();
        issue_start(1'b0, 12'd16, 13'd8);
        wait_done("t4", 1, cyc);
        toggle_ready = 1'b0;
        out_ready    = 1'b1;
        check_beats("t4", 8, 1'b0, 12'd16);
        check("t4_reads", 64'(inex_strobes), 64'(8));
        tick();

        // Zero-length dump.
        clear_log();
        issue_start(1'b0, 12'd40, 13'd0);
        check("t5_done", 64'(done), 64'(1));
        check("t5_busy", 64'(busy), 64'(1));
        check("t5_rd_en", 64'(rd_en_InexRecur || rd_en_state), 64'(0));
        check("t5_valid", 64'(out_valid), 64'(0));
        tick();
        check("t5_done_clear", 64'(done), 64'(0));
        check("t5_idle", 64'(busy), 64'(0));
        check("t5_no_reads", 64'(inex_strobes + state_strobes), 64'(0));
        check("t5_pulses", 64'(done_pulses), 64'(1));

        // Start while busy must not disturb the running dump.
        clear_log();
        issue_start(1'b0, 12'd32, 13'd3);
        start     = 1'b1;
        src_sel   = 1'b1;
        base_addr = 12'd100;
        count     = 13'd7;
        tick();
        start = 1'b0;
        wait_done("t6", 2, cyc);
        check("t6_done_cycle", 64'(cyc), 64'(5));
        check_beats("t6", 3, 1'b0, 12'd32);
        check("t6_no_state", 64'(state_strobes), 64'(0));
        tick();
        check("t6_idle", 64'(busy), 64'(0));

        // Reset in the middle of a stalled dump.
        out_ready = 1'b0;
        clear_log();
        issue_start(1'b0, 12'd64, 13'd8);
        tick();
        tick();
        check("t7_valid_before", 64'(out_valid), 64'(1));
        rst_n = 1'b0;
        tick();
        check_idle_outputs("t7_reset");
        rst_n     = 1'b1;
        out_ready = 1'b1;
        repeat (8) tick();
        check("t7_no_done", 64'(done_pulses), 64'(0));
        check("t7_idle", 64'(busy), 64'(0));
        clear_log();
        issue_start(1'b0, 12'h000, 13'd1);
        check("t7_rd_en", 64'(rd_en_InexRecur), 64'(1));
        tick();
        check("t7_data", 64'(out_data), 64'(32'h0201_0006));
        check("t7_last", 64'(out_last), 64'(1));
        tick();
        check("t7_done", 64'(done), 64'(1));
        tick();

`ifdef READBACK_CHECKSUM_EN
        inex_mem[200] = 32'h1;
        inex_mem[201] = 32'h2;
        inex_mem[202] = 32'h4;
        clear_log();
        issue_start(1'b0, 12'd200, 13'd3);
        check("t8_cleared", 64'(checksum), 64'(0));
        wait_done("t8", 1, cyc);
        check("t8_checksum", 64'(checksum), 64'(32'h7));
        tick();
        tick();
        check("t8_checksum_hold", 64'(checksum), 64'(32'h7));
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
